// File: rtl/alu_operand_mux_pipe.sv
// -----------------------------------------------------------------------------
// alu_operand_mux_pipe
//
// Registered ALU B-operand select. One of NUM_IN channels is picked by sel in
// the accept cycle. Channel CONST_CH is replaced by the built-in constant
// CONST_VAL (PC+4 style). The chosen value then passes through a valid/ready
// stage that has a one-entry skid buffer, so in_ready comes straight from a
// register. Select codes >= NUM_IN return zero and are recorded in a sticky
// flag and a saturating counter.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   data_in    flattened channels, channel k at [k*WIDTH +: WIDTH]
//   sel        channel select, sampled with in_valid
//   in_valid   upstream request
//   in_ready   stage can accept (registered)
//   data_out   selected operand (registered)
//   out_valid  data_out is valid
//   out_ready  downstream accepts
//   sel_err    sticky illegal-select flag
//   err_count  accepted illegal selects, saturating at 255
// -----------------------------------------------------------------------------
module alu_operand_mux_pipe #(
   parameter int unsigned WIDTH     = 32'd32,
   parameter int unsigned NUM_IN    = 32'd5,
   parameter int unsigned SEL_W     = 32'd3,
   parameter int unsigned CONST_CH  = 32'd1,
   parameter int unsigned CONST_VAL = 32'd4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_IN*WIDTH-1:0] data_in,
   input  logic [SEL_W-1:0]        sel,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [WIDTH-1:0]        data_out,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    sel_err,
   output logic [7:0]              err_count
);

   // Every code the select field can express gets a slot; unused slots read 0,
   // which is exactly the value an illegal select must produce.
   localparam int unsigned NUM_SLOTS = 32'd1 << SEL_W;
   localparam logic [WIDTH-1:0] CONST_W = WIDTH'(CONST_VAL);

   logic [WIDTH-1:0] chan_s [NUM_SLOTS];
   logic [WIDTH-1:0] sel_val_s;
   logic             sel_legal_s;
   logic             accept_s;
   logic             drain_s;

   logic [WIDTH-1:0] data_out_r,   data_out_n;
   logic             out_valid_r,  out_valid_n;
   logic [WIDTH-1:0] skid_data_r,  skid_data_n;
   logic             skid_valid_r, skid_valid_n;
   logic             in_ready_r,   in_ready_n;
   logic             sel_err_r,    sel_err_n;
   logic [7:0]       err_count_r,  err_count_n;

   genvar k;
   generate
      for (k = 0; k < NUM_SLOTS; k++) begin : g_chan
         if ((k == CONST_CH) && (k < NUM_IN)) begin : g_const
            assign chan_s[k] = CONST_W;
         end else if (k < NUM_IN) begin : g_data
            assign chan_s[k] = data_in[k*WIDTH +: WIDTH];
         end else begin : g_unused
            assign chan_s[k] = {WIDTH{1'b0}};
         end
      end
   endgenerate

   assign sel_legal_s = ({1'b0, sel} < (SEL_W + 32'd1)'(NUM_IN));
   assign sel_val_s   = chan_s[sel];
   assign accept_s    = in_valid & in_ready_r;
   assign drain_s     = out_valid_r & out_ready;

   // Next-state for output register, skid buffer, ready and error tracking.
   always_comb begin
      data_out_n   = data_out_r;
      out_valid_n  = out_valid_r;
      skid_data_n  = skid_data_r;
      skid_valid_n = skid_valid_r;
      in_ready_n   = in_ready_r;
      sel_err_n    = sel_err_r;
      err_count_n  = err_count_r;

      if (skid_valid_r) begin
         // in_ready is low here, so only a release can happen.
         if (drain_s) begin
            data_out_n   = skid_data_r;
            out_valid_n  = 1'b1;
            skid_valid_n = 1'b0;
            in_ready_n   = 1'b1;
         end else begin
            out_valid_n  = out_valid_r;
         end
      end else if (accept_s) begin
         if (~out_valid_r | out_ready) begin
            data_out_n  = sel_val_s;
            out_valid_n = 1'b1;
         end else begin
            skid_data_n  = sel_val_s;
            skid_valid_n = 1'b1;
            in_ready_n   = 1'b0;
         end
      end else if (drain_s) begin
         // data_out keeps the drained value; only valid drops.
         out_valid_n = 1'b0;
      end else begin
         out_valid_n = out_valid_r;
      end

      if (accept_s & ~sel_legal_s) begin
         sel_err_n = 1'b1;
         if (err_count_r != 8'hFF) begin
            err_count_n = err_count_r + 8'd1;
         end else begin
            err_count_n = err_count_r;
         end
      end else begin
         sel_err_n = sel_err_r;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_out_r   <= {WIDTH{1'b0}};
         out_valid_r  <= 1'b0;
         skid_data_r  <= {WIDTH{1'b0}};
         skid_valid_r <= 1'b0;
         in_ready_r   <= 1'b1;
         sel_err_r    <= 1'b0;
         err_count_r  <= 8'd0;
      end else begin
         data_out_r   <= data_out_n;
         out_valid_r  <= out_valid_n;
         skid_data_r  <= skid_data_n;
         skid_valid_r <= skid_valid_n;
         in_ready_r   <= in_ready_n;
         sel_err_r    <= sel_err_n;
         err_count_r  <= err_count_n;
      end
   end

   assign in_ready  = in_ready_r;
   assign data_out  = data_out_r;
   assign out_valid = out_valid_r;
   assign sel_err   = sel_err_r;
   assign err_count = err_count_r;

endmodule

// File: tb/tb_alu_operand_mux_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_operand_mux_pipe
//
// Directed steps followed by a randomized run. A reference model treats the
// stage as a two-deep FIFO of selected values and checks every DUT output on
// each falling edge, plus explicit constant checks at notable points.
// -----------------------------------------------------------------------------
module tb_alu_operand_mux_pipe;

   logic         clk = 1'b0;
   logic         reset;
   logic [159:0] data_in;
   logic [2:0]   sel;
   logic         in_valid;
   logic         in_ready;
   logic [31:0]  data_out;
   logic         out_valid;
   logic         out_ready;
   logic         sel_err;
   logic [7:0]   err_count;

   logic [31:0]  ch [5];

   int checks   = 0;
   int failures = 0;

   // reference model state
   logic [31:0]  q [$];
   logic [31:0]  m_last;
   bit           m_err;
   int           m_cnt;

   assign data_in = {ch[4], ch[3], ch[2], ch[1], ch[0]};

   alu_operand_mux_pipe dut (
      .clk       (clk),
      .reset     (reset),
      .data_in   (data_in),
      .sel       (sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data_out  (data_out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sel_err   (sel_err),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_val(input logic [2:0] s);
      if (s >= 3'd5)      return 32'd0;
      else if (s == 3'd1) return 32'd4;
      else                return ch[int'(s)];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance the model by one rising edge using the inputs currently driven.
   task automatic model_edge();
      bit acc;
      bit drn;
      if (reset) begin
         q.delete();
         m_last = 32'd0;
         m_err  = 1'b0;
         m_cnt  = 0;
      end else begin
         acc = in_valid && (q.size() < 2);
         drn = (q.size() > 0) && out_ready;
         if (drn) void'(q.pop_front());
         if (acc) begin
            q.push_back(ref_val(sel));
            if (sel >= 3'd5) begin
               m_err = 1'b1;
               if (m_cnt < 255) m_cnt++;
            end
         end
         if (q.size() > 0) m_last = q[0];
      end
   endtask

   task automatic check_all();
      chk("in_ready",  {31'd0, in_ready},  {31'd0, q.size() < 2});
      chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
      chk("data_out",  data_out, m_last);
      chk("sel_err",   {31'd0, sel_err},   {31'd0, m_err});
      chk("err_count", {24'd0, err_count}, m_cnt);
   endtask

   task automatic cycle();
      model_edge();
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   task automatic drive(input bit v, input logic [2:0] s, input logic [31:0] d, input bit rdy);
      in_valid  = v;
      sel       = s;
      out_ready = rdy;
      if (s < 3'd5) ch[int'(s)] = d;
   endtask

   initial begin
      for (int i = 0; i < 5; i++) ch[i] = 32'd0;
      reset = 1'b1; in_valid = 1'b0; sel = 3'd0; out_ready = 1'b0;
      cycle();
      cycle();
      reset = 1'b0;
      chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_data_out",  data_out, 32'd0);

      // single transfer, 1-cycle latency
      drive(1'b1, 3'd0, 32'd1, 1'b1);
      cycle();
      chk("first_data", data_out, 32'd1);
      chk("first_valid", {31'd0, out_valid}, 32'd1);
      in_valid = 1'b0;
      cycle();
      chk("first_drained", {31'd0, out_valid}, 32'd0);

      // constant channel and the remaining channels
      drive(1'b1, 3'd1, 32'hDEAD, 1'b1);
      cycle();
      chk("const_ch", data_out, 32'd4);
      drive(1'b1, 3'd2, 32'd3, 1'b1); cycle(); chk("ch2", data_out, 32'd3);
      drive(1'b1, 3'd3, 32'd4, 1'b1); cycle(); chk("ch3", data_out, 32'd4);
      drive(1'b1, 3'd4, 32'd5, 1'b1); cycle(); chk("ch4", data_out, 32'd5);
      in_valid = 1'b0;
      cycle();

      // skid buffer fill and release, FIFO order 10, 11, 12
      drive(1'b1, 3'd0, 32'd10, 1'b1); cycle();
      drive(1'b1, 3'd0, 32'd11, 1'b0); cycle();
      chk("skid_hold10", data_out, 32'd10);
      chk("skid_ready0", {31'd0, in_ready}, 32'd0);
      drive(1'b1, 3'd0, 32'd12, 1'b0); cycle();
      chk("skid_still10", data_out, 32'd10);
      chk("skid_blocked", {31'd0, in_ready}, 32'd0);
      out_ready = 1'b1; cycle();
      chk("release11", data_out, 32'd11);
      chk("release_ready", {31'd0, in_ready}, 32'd1);
      cycle();
      chk("order12", data_out, 32'd12);
      in_valid = 1'b0; cycle();
      chk("hold_after_drain", data_out, 32'd12);

      // illegal selects
      drive(1'b1, 3'd6, 32'd0, 1'b1); cycle(); chk("illegal_zero1", data_out, 32'd0);
      cycle(); chk("illegal_zero2", data_out, 32'd0);
      drive(1'b1, 3'd0, 32'd9, 1'b1); cycle();
      chk("sticky_err", {31'd0, sel_err}, 32'd1);
      chk("err_cnt2", {24'd0, err_count}, 32'd2);
      in_valid = 1'b0; cycle();

      // reset with the skid buffer full
      drive(1'b1, 3'd0, 32'd20, 1'b0); cycle();
      drive(1'b1, 3'd0, 32'd21, 1'b0); cycle();
      chk("pre_rst_full", {31'd0, in_ready}, 32'd0);
      in_valid = 1'b0; reset = 1'b1; cycle(); reset = 1'b0;
      chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
      chk("mid_rst_err",   {31'd0, sel_err}, 32'd0);
      chk("mid_rst_cnt",   {24'd0, err_count}, 32'd0);

      // streaming 0..7
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 3'd0, i, 1'b1);
         cycle();
         chk("stream_data", data_out, i);
         chk("stream_ready", {31'd0, in_ready}, 32'd1);
      end
      in_valid = 1'b0; cycle();

      // err_count saturation
      for (int i = 0; i < 260; i++) begin
         drive(1'b1, 3'd7, 32'd0, 1'b1);
         cycle();
      end
      chk("err_sat", {24'd0, err_count}, 32'd255);
      in_valid = 1'b0; cycle();

      // randomized traffic with occasional reset
      for (int i = 0; i < 600; i++) begin
         for (int c = 0; c < 5; c++) ch[c] = $urandom;
         sel       = 3'($urandom_range(0, 7));
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         reset     = ($urandom_range(0, 63) == 0);
         cycle();
      end
      reset = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_operand_mux_pipe.md
Name: alu_operand_mux_pipe

Overview:
- Parametrised, registered successor to the combinational ALU B-operand select mux.
- Selects one of NUM_IN operand channels and can substitute a built-in constant channel (the PC+4 style constant).
- Passes the result through a valid/ready pipeline stage with a one-entry skid buffer, so the ALU operand path can be pipelined without combinational ready paths.
- Flags illegal select codes.

Parameters:
- WIDTH, 32, data width of each channel and of data_out.
- NUM_IN, 5, number of channels (2..8); channel CONST_CH is replaced by CONST_VAL.
- SEL_W, 3, select width; must satisfy 2^SEL_W >= NUM_IN.
- CONST_CH, 1, index of the constant channel; a value >= NUM_IN disables the constant.
- CONST_VAL, 4, value driven for CONST_CH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- data_in  input  NUM_IN*WIDTH  flattened channels; channel k occupies bits [k*WIDTH +: WIDTH].
- sel  input  SEL_W  channel select, sampled with in_valid.
- in_valid  input  1  upstream request.
- in_ready  output  1  block can accept a request; driven from a register (no combinational path from out_ready).
- data_out  output  WIDTH  selected operand.
- out_valid  output  1  data_out is valid.
- out_ready  input  1  downstream accepts.
- sel_err  output  1  sticky illegal-select flag.
- err_count  output  8  number of accepted illegal selects, saturating at 255.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port reset.
- Reset values:
  - data_out = 0, out_valid = 0, in_ready = 1.
  - Skid buffer empty, skid data = 0.
  - sel_err = 0, err_count = 0.
- Reset mid-operation discards both the output and skid entries; no transfer completes in the reset cycle.
- Handshake terms:
  - Accept = in_valid & in_ready.
  - Drain = out_valid & out_ready.
- Selection, computed in the accept cycle:
  - sel < NUM_IN and sel != CONST_CH: value = channel sel.
  - sel == CONST_CH: value = CONST_VAL, zero-extended or truncated to WIDTH.
  - sel >= NUM_IN: value = 0. On accept, sel_err is set and err_count increments (saturating at 255). The transfer still completes with value 0.
- Pipeline latency: 1 cycle from accept to out_valid when the stage is empty or draining.
- Output register loads on accept when (~out_valid | out_ready).
- Skid path:
  - If accept occurs while out_valid & ~out_ready, the value goes to the skid buffer.
  - in_ready drops to 0 on the next cycle.
- Skid release: when the skid buffer is full and drain occurs, the skid value moves to the output register (out_valid stays 1). The skid buffer empties and in_ready returns to 1 on the next cycle.
- No accept can occur while the skid buffer is full, because in_ready = 0.
- Ordering: strictly FIFO; no value is dropped or duplicated.
- data_out holds its value while out_valid & ~out_ready.
- data_out is unchanged (not cleared) after a drain with no new load.
- Simultaneous accept and drain with skid empty: the new value loads the output register and out_valid stays 1.
- data_in and sel are don't-care when in_valid = 0.

Test Plan:
- After reset, sel=0, data_in ch0=1, in_valid=1 for one cycle, out_ready=1 -> next cycle data_out=1, out_valid=1; the cycle after, out_valid=0.
- sel=1 with ch1=0xDEAD -> data_out=4 (constant), not 0xDEAD. Then sel=2 with ch2=3 -> 3; sel=3 with ch3=4 -> 4; sel=4 with ch4=5 -> 5. All at 1-cycle latency.
- Back-to-back accepts of 10, 11, 12 with out_ready=0 after the first:
  - Result: 10 held at data_out, 11 in the skid buffer, in_ready=0, 12 not accepted.
  - Raise out_ready: outputs appear in order 10, 11, 12.
- sel=6 (NUM_IN=5), accepted twice -> data_out=0 each time, sel_err=1, err_count=2. A later legal sel leaves sel_err=1.
- Skid full and out_valid=1, assert reset for one cycle -> out_valid=0, in_ready=1, sel_err=0, err_count=0 in the following cycle.
- Streaming with out_ready=1 and in_valid=1 for 8 cycles, values 0..7 -> in_ready stays 1, outputs 0..7 in consecutive cycles.
